// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//
// Contents:
//   DEFAULT_WIDTH / DEFAULT_DEPTH  default geometry of the register file
//   MAX_WIDTH / MAX_AW             widest data word / address the helper handles
//   ZERO_ADDR                      address of the optional hardwired-zero register
//   wr_pick_t                      resolved (hit, data) pair for one address
//   resolve_write()                folds the two write ports into one (hit, data)
//                                  pair for a given address, port B over port A
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  // The helper works on fixed maximum widths so one function serves every
  // parameterisation; callers zero-extend inputs and keep the low WIDTH bits.
  localparam int MAX_WIDTH = 128;
  localparam int MAX_AW    = 16;

  localparam logic [MAX_AW-1:0] ZERO_ADDR = '0;

  typedef struct packed {
    logic                 hit;
    logic [MAX_WIDTH-1:0] data;
  } wr_pick_t;

  // Decide which write (if any) lands on 'addr' this cycle. Port B carries
  // loads/IO and is the later producer, so it wins a same-address collision.
  // With the zero register enabled, address 0 never sees a write.
  function automatic wr_pick_t resolve_write(
    input logic [MAX_AW-1:0]    addr,
    input logic                 zero_reg,
    input logic                 en_a,
    input logic [MAX_AW-1:0]    addr_a,
    input logic [MAX_WIDTH-1:0] data_a,
    input logic                 en_b,
    input logic [MAX_AW-1:0]    addr_b,
    input logic [MAX_WIDTH-1:0] data_b
  );
    wr_pick_t pick;
    pick.hit  = 1'b0;
    pick.data = '0;
    if (!(zero_reg && (addr == ZERO_ADDR))) begin
      if (en_b && (addr_b == addr)) begin
        pick.hit  = 1'b1;
        pick.data = data_b;
      end else if (en_a && (addr_a == addr)) begin
        pick.hit  = 1'b1;
        pick.data = data_a;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a long-latency
// producer is issued and cleared when a write to that register commits.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   set_en      mark set_addr as having a pending write
//   set_addr    register to mark
//   clr         per-register clear request (committed writes this cycle)
//   bits        current scoreboard state (registered)
//   bits_next   scoreboard state after this edge's update (combinational)
//   any_busy    registered OR of the state after the update
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic [DEPTH-1:0] clr,
  output logic [DEPTH-1:0] bits,
  output logic [DEPTH-1:0] bits_next,
  output logic             any_busy
);

  logic [DEPTH-1:0] set_mask;

  // Next-state vector. The set is applied after the clear so a new producer
  // issued in the same cycle as the old one's writeback keeps the bit busy.
  always_comb begin
    set_mask = '0;
    if (set_en && !(ZERO_REG && (set_addr == AW'(0)))) begin
      set_mask[set_addr] = 1'b1;
    end
    bits_next = (bits & ~clr) | set_mask;
    if (ZERO_REG) begin
      bits_next[0] = 1'b0;
    end
  end

  // any_busy is computed from the post-update vector so it lines up with
  // the scoreboard contents at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits     <= '0;
      any_busy <= 1'b0;
    end else begin
      bits     <= bits_next;
      any_busy <= |bits_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port CPU register file.
//
// NUM_RD registered read ports, two write ports (A: ALU writeback,
// B: load/IO writeback, B wins on collision), optional write-through
// bypass, optional hardwired-zero register 0, synchronous clear, and a
// per-register pending-write scoreboard reported alongside read data.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   rd_addr           packed read addresses, port i at [i*AW +: AW]
//   rd_data           packed registered read data, port i at [i*WIDTH +: WIDTH]
//   rd_busy           registered scoreboard bit for each read address
//   wr_en_a/addr_a/data_a   write port A
//   wr_en_b/addr_b/data_b   write port B
//   busy_set, busy_addr     scoreboard set request
//   any_busy          registered OR of all scoreboard bits
//
// WIDTH must not exceed regfile_pkg::MAX_WIDTH and AW must not exceed MAX_AW.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    wr_en_a,
  input  logic [AW-1:0]           wr_addr_a,
  input  logic [WIDTH-1:0]        wr_data_a,
  input  logic                    wr_en_b,
  input  logic [AW-1:0]           wr_addr_b,
  input  logic [WIDTH-1:0]        wr_data_b,
  input  logic                    busy_set,
  input  logic [AW-1:0]           busy_addr,
  output logic                    any_busy
);

  localparam bit ZERO_EN   = (ZERO_REG != 0);
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [MAX_AW-1:0]    wa_ext;
  logic [MAX_AW-1:0]    wb_ext;
  logic [MAX_WIDTH-1:0] wda_ext;
  logic [MAX_WIDTH-1:0] wdb_ext;

  logic [DEPTH-1:0] commit_hit;
  logic [WIDTH-1:0] commit_data [DEPTH];
  logic             unused_commit_hi;

  logic [DEPTH-1:0] busy_cur;
  logic [DEPTH-1:0] busy_next;

  assign wa_ext  = MAX_AW'(wr_addr_a);
  assign wb_ext  = MAX_AW'(wr_addr_b);
  assign wda_ext = MAX_WIDTH'(wr_data_a);
  assign wdb_ext = MAX_WIDTH'(wr_data_b);

  // Per-register commit decision. The same resolver drives the read bypass,
  // so what a bypassed read shows is exactly what the array will hold.
  always_comb begin
    wr_pick_t pick;
    commit_hit       = '0;
    commit_data      = '{default: '0};
    unused_commit_hi = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      pick = resolve_write(MAX_AW'(k), ZERO_EN,
                           wr_en_a, wa_ext, wda_ext,
                           wr_en_b, wb_ext, wdb_ext);
      commit_hit[k]    = pick.hit;
      commit_data[k]   = pick.data[WIDTH-1:0];
      unused_commit_hi = unused_commit_hi ^ (^pick.data);
    end
  end

  // Storage array with synchronous clear; reset discards same-cycle writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (commit_hit[k]) begin
          mem[k] <= commit_data[k];
        end
      end
    end
  end

  // Committed writes clear their scoreboard bit; busy_set re-arms it.
  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_EN)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (busy_set),
    .set_addr  (busy_addr),
    .clr       (commit_hit),
    .bits      (busy_cur),
    .bits_next (busy_next),
    .any_busy  (any_busy)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]    port_addr;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             busy_d;
    logic             busy_q;
    logic             unused_hi;

    assign port_addr = rd_addr[i*AW +: AW];

    // With bypass, data and busy both show the state after this edge's
    // updates; without it, both show the pre-update state.
    always_comb begin
      wr_pick_t pick;
      pick      = resolve_write(MAX_AW'(port_addr), ZERO_EN,
                                wr_en_a, wa_ext, wda_ext,
                                wr_en_b, wb_ext, wdb_ext);
      unused_hi = ^pick.data;
      data_d    = mem[port_addr];
      busy_d    = busy_cur[port_addr];
      if (BYPASS_EN) begin
        busy_d = busy_next[port_addr];
        if (pick.hit) begin
          data_d = pick.data[WIDTH-1:0];
        end
      end
      if (ZERO_EN && (port_addr == AW'(0))) begin
        data_d = '0;
        busy_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end

    assign rd_data[i*WIDTH +: WIDTH] = data_q;
    assign rd_busy[i]                = busy_q;
  end

endmodule
